// File: rtl/canasta_pkg.sv
// Shared definitions for the basket-position acquisition path.
// Holds the converter FSM encoding, frame geometry constants and a period helper.
// No logic; imported by lector_adc and its sub-module.
package canasta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    GAP  = 2'd2
  } estado_t;

  localparam int N_BITS_ADC  = 8;
  localparam int SETUP_CLKS  = 1;
  localparam int HALF_PHASES = 18;
  localparam int GAP_HALVES  = 2;

  // First high half-phase that carries a data bit (pulse SETUP_CLKS+1).
  localparam int FIRST_DATA_HALF = 2 * SETUP_CLKS + 1;

  // Effective CS-to-CS period: a frame plus its guard gap is the floor.
  function automatic int periodo_efectivo(input int sample_period, input int clk_div);
    int minimo;
    minimo = (HALF_PHASES + GAP_HALVES) * clk_div;
    return (sample_period > minimo) ? sample_period : minimo;
  endfunction

endpackage

// File: rtl/lector_adc_divisor_sclk.sv
// Half-phase timebase: counts 0..CLK_DIV-1 and flags the last cycle of each half-phase.
// Latency: tick is combinational from the count; clear takes effect on the next edge.
// No backpressure; clear holds the count at zero.
module divisor_sclk #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] cnt;

  // Free-running half-phase counter, wrapped at CLK_DIV-1 and held at 0 by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == W'(CLK_DIV - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == W'(CLK_DIV - 1));

endmodule

// File: rtl/lector_adc.sv
// Periodic ADC0831-style serial reader: CS/SCLK generation, DO capture, 8-bit sample strobe.
// Latency: 18*CLK_DIV clocks from CS falling to dato_valido; one sample per effective period.
// No backpressure: dato_valido is a one-cycle pulse and dato holds until the next one.
module lector_adc
  import canasta_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  habilitar,
  input  logic                  adc_dout,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic [N_BITS_ADC-1:0] dato,
  output logic                  dato_valido,
  output logic                  ocupado
);

  localparam int PERIODO = periodo_efectivo(SAMPLE_PERIOD, CLK_DIV);
  localparam int TERM    = PERIODO - 1;
  localparam int PW      = $clog2(PERIODO);
  // Last GAP cycle, measured on the period counter. Leaving GAP here puts the
  // single IDLE cycle on the terminal count, so at the minimum period the next
  // CS fall lands exactly one period after the previous one while CS has still
  // been high for GAP_HALVES*CLK_DIV cycles.
  localparam int GAP_EXIT = (HALF_PHASES + GAP_HALVES) * CLK_DIV - 2;

  estado_t               estado, estado_sig;
  logic                  sync_q1, sync_q2;
  logic                  tick;
  logic [4:0]            idx_fase;
  logic [PW-1:0]         cnt_periodo;
  logic                  periodo_fresco;
  logic [N_BITS_ADC-1:0] sreg, sreg_sig;
  logic                  vencido, arranque, fin_conv, fin_gap, muestra;

  assign vencido  = periodo_fresco || (cnt_periodo == PW'(TERM));
  assign arranque = (estado == IDLE) && habilitar && vencido;
  assign fin_conv = (estado == CONV) && tick && (idx_fase == 5'(HALF_PHASES - 1));
  assign fin_gap  = (estado == GAP) && (cnt_periodo >= PW'(GAP_EXIT));
  // Odd half-phases are SCLK high; the setup pulse is skipped.
  assign muestra  = (estado == CONV) && tick && idx_fase[0] &&
                    (idx_fase >= 5'(FIRST_DATA_HALF));
  assign sreg_sig = {sreg[N_BITS_ADC-2:0], sync_q2};

  divisor_sclk #(
    .CLK_DIV(CLK_DIV)
  ) u_divisor (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(estado != CONV),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous ADC data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= adc_dout;
      sync_q2 <= sync_q1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  // FSM next-state: start on enable + expired period, finish after 18 half-phases, guard gap.
  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (arranque) estado_sig = CONV;
      CONV:    if (fin_conv) estado_sig = GAP;
      GAP:     if (fin_gap)  estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  // Half-phase index within a frame; restarts at every CS fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_fase <= '0;
    end else if (arranque) begin
      idx_fase <= '0;
    end else if ((estado == CONV) && tick) begin
      idx_fase <= fin_conv ? 5'd0 : idx_fase + 5'd1;
    end
  end

  // Period counter: restarts at CS fall, saturates at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_periodo    <= '0;
      periodo_fresco <= 1'b1;
    end else if (arranque) begin
      cnt_periodo    <= '0;
      periodo_fresco <= 1'b0;
    end else if (cnt_periodo != PW'(TERM)) begin
      cnt_periodo <= cnt_periodo + 1'b1;
    end
  end

  // Shift register: MSB-first capture at the end of each data-bearing high phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (arranque) begin
      sreg <= '0;
    end else if (muestra) begin
      sreg <= sreg_sig;
    end
  end

  // ADC control pins and busy flag, all straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs_n <= 1'b1;
      ocupado  <= 1'b0;
      adc_sclk <= 1'b0;
    end else begin
      if (arranque) begin
        adc_cs_n <= 1'b0;
        ocupado  <= 1'b1;
      end else if (fin_conv) begin
        adc_cs_n <= 1'b1;
        ocupado  <= 1'b0;
      end
      // Ending a low half-phase raises SCLK, ending a high one lowers it.
      if ((estado == CONV) && tick) begin
        adc_sclk <= ~idx_fase[0];
      end
    end
  end

  // Sample publication: the final bit is shifted in on the same edge that publishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dato        <= '0;
      dato_valido <= 1'b0;
    end else begin
      dato_valido <= fin_conv;
      if (fin_conv) begin
        dato <= sreg_sig;
      end
    end
  end

endmodule

// File: tb/tb_lector_adc.sv
// Bench for lector_adc: two instances (long period and below-minimum period) with ADC models.
// Expected codes come from the model queues; frame timing from the serial-ADC timing rules.
// Each scenario task checks its own results inline.
module tb_lector_adc;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hab_a = 1'b0, dout_a = 1'b0, cs_a, sclk_a, vld_a, ocu_a;
  logic [7:0] dato_a;
  logic       hab_b = 1'b0, dout_b = 1'b0, cs_b, sclk_b, vld_b, ocu_b;
  logic [7:0] dato_b;

  int errors = 0;
  int checks = 0;
  int since_a = 0;

  logic [7:0] code_q_a[$];
  logic [7:0] code_q_b[$];
  bit         noise_a = 1'b0;

  always #5 clk = ~clk;

  lector_adc #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(200)) dut (
    .clk(clk), .rst_n(rst_n), .habilitar(hab_a), .adc_dout(dout_a),
    .adc_cs_n(cs_a), .adc_sclk(sclk_a), .dato(dato_a), .dato_valido(vld_a), .ocupado(ocu_a));

  lector_adc #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(10)) dut_min (
    .clk(clk), .rst_n(rst_n), .habilitar(hab_b), .adc_dout(dout_b),
    .adc_cs_n(cs_b), .adc_sclk(sclk_b), .dato(dato_b), .dato_valido(vld_b), .ocupado(ocu_b));

  // ADC model A: leading 0 at CS fall, then code MSB first on each SCLK fall.
  logic       prev_cs_a = 1'b1, prev_sclk_a = 1'b0, bit_a = 1'b0;
  logic [7:0] cur_a = 8'h00;
  int         bidx_a = 0;
  always @(negedge clk) begin
    if (prev_cs_a && !cs_a) begin
      cur_a  = (code_q_a.size() > 0) ? code_q_a.pop_front() : 8'($urandom);
      bidx_a = 0;
      bit_a  = 1'b0;
    end else if (!cs_a && prev_sclk_a && !sclk_a) begin
      if (bidx_a < 8) bit_a = cur_a[3'(7 - bidx_a)];
      bidx_a++;
    end
    prev_cs_a   = cs_a;
    prev_sclk_a = sclk_a;
    dout_a = (noise_a && !cs_a && !sclk_a) ? 1'($urandom) : bit_a;
  end

  // ADC model B, same protocol.
  logic       prev_cs_b = 1'b1, prev_sclk_b = 1'b0, bit_b = 1'b0;
  logic [7:0] cur_b = 8'h00;
  int         bidx_b = 0;
  always @(negedge clk) begin
    if (prev_cs_b && !cs_b) begin
      cur_b  = (code_q_b.size() > 0) ? code_q_b.pop_front() : 8'($urandom);
      bidx_b = 0;
      bit_b  = 1'b0;
    end else if (!cs_b && prev_sclk_b && !sclk_b) begin
      if (bidx_b < 8) bit_b = cur_b[3'(7 - bidx_b)];
      bidx_b++;
    end
    prev_cs_b   = cs_b;
    prev_sclk_b = sclk_b;
    dout_b      = bit_b;
  end

  // Downstream 8-bit to 640-pixel screen coordinate.
  function automatic int conv(input logic [7:0] x);
    return (int'(x) * 640) >> 8;
  endfunction

  task automatic peek(input bit sel, output logic c, output logic s, output logic v,
                      output logic o, output logic [7:0] dd);
    if (sel) begin c = cs_b; s = sclk_b; v = vld_b; o = ocu_b; dd = dato_b; end
    else     begin c = cs_a; s = sclk_a; v = vld_a; o = ocu_a; dd = dato_a; end
  endtask

  // Waits for CS fall, then follows the frame until dato_valido; returns one negedge after it.
  task automatic run_frame(input bit sel, input int drop_at, input logic [7:0] hold_val,
                           output int wait_c, output int pulses, output int lat,
                           output logic [7:0] d, output int sper_bad, output int hold_bad,
                           output int busy_bad, output bit to);
    logic c, s, v, o, ps;
    logic [7:0] dd;
    int n, last;
    to = 1'b0; wait_c = 0; pulses = 0; lat = -1; d = 8'h00;
    sper_bad = 0; hold_bad = 0; busy_bad = 0;
    peek(sel, c, s, v, o, dd);
    while (c !== 1'b0 && wait_c < 5000) begin
      if (dd !== hold_val) hold_bad++;
      if (o !== ~c) busy_bad++;
      @(negedge clk);
      wait_c++;
      peek(sel, c, s, v, o, dd);
    end
    if (c !== 1'b0) begin to = 1'b1; return; end
    n = 0; ps = 1'b0; last = -1;
    while (lat < 0 && n < 400) begin
      peek(sel, c, s, v, o, dd);
      if (o !== ~c) busy_bad++;
      if (s === 1'b1 && ps === 1'b0) begin
        pulses++;
        if (last >= 0 && (n - last) != 2 * CLK_DIV) sper_bad++;
        last = n;
        if (!sel && pulses == drop_at) hab_a = 1'b0;
      end
      ps = s;
      if (v === 1'b1) begin lat = n; d = dd; end
      @(negedge clk);
      n++;
    end
    if (lat < 0) to = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hab_a = 1'b0; hab_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs_a !== 1'b1)   begin errors++; $display("FAIL reset_cs: got %b want 1", cs_a); end
    checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk_a); end
    checks++; if (dato_a !== 8'h00) begin errors++; $display("FAIL reset_dato: got %h want 00", dato_a); end
    checks++; if (vld_a !== 1'b0)  begin errors++; $display("FAIL reset_valido: got %b want 0", vld_a); end
    checks++; if (ocu_a !== 1'b0)  begin errors++; $display("FAIL reset_ocupado: got %b want 0", ocu_a); end
    checks++; if (cs_b !== 1'b1 || dato_b !== 8'h00)
      begin errors++; $display("FAIL reset_b: got cs=%b dato=%h want 1/00", cs_b, dato_b); end
  endtask

  task automatic test_first_frame();
    int w, p, lat, sb, hb, bb;
    logic [7:0] d;
    bit to;
    code_q_a.push_back(8'hA5);
    hab_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0, 0, 8'h00, w, p, lat, d, sb, hb, bb, to);
    checks++; if (to)         begin errors++; $display("FAIL first_timeout: got timeout want frame"); end
    checks++; if (w != 1)     begin errors++; $display("FAIL first_cs_delay: got %0d want 1", w); end
    checks++; if (p != 9)     begin errors++; $display("FAIL first_pulses: got %0d want 9", p); end
    checks++; if (sb != 0)    begin errors++; $display("FAIL first_sclk_period: got %0d bad want 0", sb); end
    checks++; if (lat != 72)  begin errors++; $display("FAIL first_latency: got %0d want 72", lat); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL first_dato: got %h want a5", d); end
    checks++; if (conv(d) != 412) begin errors++; $display("FAIL first_conv: got %0d want 412", conv(d)); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL first_pulse_width: got %b want 0", vld_a); end
    checks++; if (bb != 0 || hb != 0)
      begin errors++; $display("FAIL first_ocupado_hold: got %0d/%0d want 0/0", bb, hb); end
    since_a = lat + 1;
  endtask

  task automatic test_consecutive();
    logic [7:0] codes[2];
    int want_conv[2];
    logic [7:0] prev, d;
    int w, p, lat, sb, hb, bb;
    bit to;
    codes[0] = 8'hFF; codes[1] = 8'h00;
    want_conv[0] = 637; want_conv[1] = 0;
    prev = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      code_q_a.push_back(codes[k]);
      run_frame(1'b0, 0, prev, w, p, lat, d, sb, hb, bb, to);
      checks++; if (to || since_a + w != 200)
        begin errors++; $display("FAIL consec_interval%0d: got %0d want 200", k, since_a + w); end
      checks++; if (d !== codes[k])
        begin errors++; $display("FAIL consec_dato%0d: got %h want %h", k, d, codes[k]); end
      checks++; if (conv(d) != want_conv[k])
        begin errors++; $display("FAIL consec_conv%0d: got %0d want %0d", k, conv(d), want_conv[k]); end
      checks++; if (hb != 0)
        begin errors++; $display("FAIL consec_hold%0d: got %0d changes want 0", k, hb); end
      since_a = lat + 1;
      prev = codes[k];
    end
    hab_a = 1'b0;
  endtask

  task automatic test_min_period();
    logic [7:0] c, d, prev;
    int w, p, lat, sb, hb, bb, since;
    bit to;
    prev = 8'h00; since = 0;
    hab_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c = 8'($urandom);
      code_q_b.push_back(c);
      run_frame(1'b1, 0, prev, w, p, lat, d, sb, hb, bb, to);
      if (k == 0) begin
        checks++; if (w != 1) begin errors++; $display("FAIL minp_first_delay: got %0d want 1", w); end
      end else begin
        checks++; if (since + w != 80)
          begin errors++; $display("FAIL minp_interval%0d: got %0d want 80", k, since + w); end
        checks++; if (w + 1 < 8)
          begin errors++; $display("FAIL minp_cs_high%0d: got %0d want >=8", k, w + 1); end
      end
      checks++; if (to || lat != 72 || d !== c)
        begin errors++; $display("FAIL minp_frame%0d: got lat=%0d dato=%h want 72/%h", k, lat, d, c); end
      since = lat + 1;
      prev = c;
    end
    hab_b = 1'b0;
  endtask

  task automatic test_habilitar_drop();
    logic [7:0] c, d;
    int w, p, lat, sb, hb, bb, falls;
    bit to;
    c = 8'($urandom_range(1, 255));
    code_q_a.push_back(c);
    hab_a = 1'b1;
    run_frame(1'b0, 5, 8'h00, w, p, lat, d, sb, hb, bb, to);
    checks++; if (w != 1) begin errors++; $display("FAIL drop_start: got %0d want 1", w); end
    checks++; if (to || p != 9 || lat != 72)
      begin errors++; $display("FAIL drop_complete: got pulses=%0d lat=%0d want 9/72", p, lat); end
    checks++; if (d !== c) begin errors++; $display("FAIL drop_dato: got %h want %h", d, c); end
    falls = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cs_a !== 1'b1) falls++;
    end
    checks++; if (falls != 0) begin errors++; $display("FAIL drop_parked: got %0d low cycles want 0", falls); end
    code_q_a.push_back(8'($urandom));
    hab_a = 1'b1;
    @(negedge clk);
    checks++; if (cs_a !== 1'b0) begin errors++; $display("FAIL drop_reassert: got cs=%b want 0", cs_a); end
    checks++; if (dato_a !== c) begin errors++; $display("FAIL drop_hold: got %h want %h", dato_a, c); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] z, d;
    logic ps;
    int rises, n, bad, w, p, lat, sb, hb, bb;
    bit to;
    rises = 0; n = 0; ps = sclk_a;
    while (rises < 6 && n < 200) begin
      @(negedge clk);
      n++;
      if (sclk_a === 1'b1 && ps === 1'b0) rises++;
      ps = sclk_a;
    end
    checks++; if (rises != 6) begin errors++; $display("FAIL rstmid_reach: got %0d pulses want 6", rises); end
    rst_n = 1'b0;
    #1;
    checks++; if (cs_a !== 1'b1 || sclk_a !== 1'b0)
      begin errors++; $display("FAIL rstmid_pins: got cs=%b sclk=%b want 1/0", cs_a, sclk_a); end
    checks++; if (dato_a !== 8'h00 || ocu_a !== 1'b0 || vld_a !== 1'b0)
      begin errors++; $display("FAIL rstmid_outs: got dato=%h ocu=%b vld=%b want 00/0/0", dato_a, ocu_a, vld_a); end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (vld_a !== 1'b0 || cs_a !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d bad cycles want 0", bad); end
    z = 8'($urandom);
    code_q_a.push_back(z);
    rst_n = 1'b1;
    run_frame(1'b0, 0, 8'h00, w, p, lat, d, sb, hb, bb, to);
    checks++; if (to || w != 1 || p != 9 || lat != 72)
      begin errors++; $display("FAIL rstmid_fresh: got w=%0d p=%0d lat=%0d want 1/9/72", w, p, lat); end
    checks++; if (d !== z) begin errors++; $display("FAIL rstmid_dato: got %h want %h", d, z); end
    since_a = lat + 1;
  endtask

  task automatic test_noise();
    logic [7:0] c, d, prev;
    int w, p, lat, sb, hb, bb;
    bit to;
    prev = dato_a;
    noise_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c = 8'($urandom);
      code_q_a.push_back(c);
      run_frame(1'b0, 0, prev, w, p, lat, d, sb, hb, bb, to);
      checks++; if (to || since_a + w != 200)
        begin errors++; $display("FAIL noise_interval%0d: got %0d want 200", k, since_a + w); end
      checks++; if (d !== c) begin errors++; $display("FAIL noise_dato%0d: got %h want %h", k, d, c); end
      since_a = lat + 1;
      prev = c;
    end
    noise_a = 1'b0;
    hab_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_consecutive();
    test_min_period();
    test_habilitar_drop();
    test_reset_mid();
    test_noise();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lector_adc.md
Name: lector_adc

Overview:
- Upstream acquisition stage of the Canasta basket-position path.
- Periodically runs an 8-bit serial ADC conversion (ADC0831-style: CS, SCLK, DO) on the player's potentiometer.
- Publishes each result as an 8-bit sample with a one-cycle valid strobe.
- The sample feeds the 8-bit-to-10-bit screen-coordinate converter directly downstream.

Parameters:
- CLK_DIV, 25, system clocks per SCLK half-period; legal range is 4 or more.
- SAMPLE_PERIOD, 50000, system clocks between successive CS falling edges. The effective period is max(SAMPLE_PERIOD, 20*CLK_DIV).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- habilitar  input  1  level; 1 allows conversions to start.
- adc_dout  input  1  serial data from the ADC. Asynchronous; passes through a 2-flop synchronizer before use.
- adc_cs_n  output  1  ADC chip select, active low, registered.
- adc_sclk  output  1  ADC serial clock, registered; idles low.
- dato  output  8  last completed sample; held until the next completion.
- dato_valido  output  1  one-cycle pulse when dato updates.
- ocupado  output  1  high while adc_cs_n is low.

Behaviour:
- Reset values (async, immediate, including mid-conversion):
  - adc_cs_n=1, adc_sclk=0, dato=0x00, dato_valido=0, ocupado=0.
  - State=IDLE; all counters 0; shift register 0.
- States: IDLE, CONV, GAP.
- IDLE:
  - Moves to CONV when habilitar=1 and the period counter has expired.
  - The period counter is already expired after reset.
  - On the transition edge: adc_cs_n goes to 0, ocupado goes to 1, the period counter restarts at 0, and the half-phase counter is cleared.
- CONV:
  - 18 half-phases of CLK_DIV cycles each: low, high, low, high, ...; adc_sclk follows the phase.
  - SCLK pulse 1 is the mux-setup clock. Its sample is discarded.
  - On SCLK pulses 2..9, the synchronized adc_dout is sampled on the last clk cycle of each high phase and shifted in MSB first.
  - At the edge ending the 18th half-phase, all of the following happen together: adc_sclk=0, adc_cs_n=1, ocupado=0, dato takes the shift-register value, dato_valido=1 for exactly one cycle, and the FSM moves to GAP.
  - Latency: from the edge where adc_cs_n falls to the edge where dato_valido rises is 18*CLK_DIV clk cycles.
- GAP:
  - adc_cs_n is held high for at least 2*CLK_DIV cycles, then the FSM returns to IDLE.
  - IDLE waits until the period counter reaches max(SAMPLE_PERIOD, 20*CLK_DIV) - 1 before starting the next conversion.
- habilitar:
  - Sampled only in IDLE.
  - Deasserting it during CONV or GAP does not abort. The conversion completes, dato_valido fires, and the FSM then parks in IDLE.
  - Re-asserting it after a long idle starts a conversion on the next edge, because the period counter saturates once expired.
- Counters:
  - Half-phase divider counts 0..CLK_DIV-1. Half-phase index counts 0..17.
  - Period counter saturates at its terminal value, so it never wraps.
- Data: no arithmetic on the sample. dato is the raw code 0x00..0xFF; the downstream converter scales it.
- Outputs are glitch-free: every output is driven directly from a flop.

Decomposition:
- canasta_pkg:
  - State encoding (IDLE, CONV, GAP).
  - N_BITS_ADC=8, SETUP_CLKS=1, HALF_PHASES=18, GAP_HALVES=2.
- One sub-module, divisor_sclk:
  - Parameterized by CLK_DIV.
  - Inputs: clk, rst_n, a clear input.
  - Output: a one-cycle tick at the end of each half-phase.
  - Instantiated once.
- The synchronizer, shift register and FSM stay in lector_adc.

Test Plan (bench CLK_DIV=4; ADC model drives DO on the falling SCLK edge: one leading 0 for the setup clock, then the code MSB first):
1. Reset, habilitar=1, SAMPLE_PERIOD=200, model code 0xA5 -> adc_cs_n falls 1 cycle after reset release; exactly 9 SCLK pulses of period 8 clk; dato=0xA5 with dato_valido high 1 cycle, 72 cycles after the CS fall. The downstream converter then outputs 412.
2. Model codes 0xFF then 0x00 on consecutive conversions -> dato=0xFF (converter output 637), then dato=0x00 (converter output 0). CS falling edges are exactly 200 cycles apart; dato holds between pulses.
3. SAMPLE_PERIOD=10, which is below the minimum -> CS falling edges are 80 cycles apart; CS is high at least 8 cycles between frames; no dato_valido is ever missed.
4. Drop habilitar at the 5th SCLK pulse -> the frame completes and delivers the correct code; no further CS fall occurs. Re-assert 1000 cycles later -> CS falls on the next edge.
5. Assert rst_n=0 at SCLK pulse 6 -> immediately adc_cs_n=1, adc_sclk=0, dato=0x00, ocupado=0, no dato_valido pulse. After release, a full fresh frame runs and its result is correct.
6. Toggle adc_dout during SCLK low phases only -> sampled bits match the values present at the end of each high phase, confirming the synchronizer plus sampling-point timing.
